glyph_plotter: RTL and testbench

Receives the coordinate stream produced by the glyph drawers (F and siblings) and turns it into VGA adapter plot writes. Sits between the drawers and the 160x120 VGA adapter. Buffers points in a small FIFO, discards off-screen and consecutively repeated points, and runs a full-screen clear sweep on request. Its output handshake lets the plotter share the adapter with other writers.

---
 rtl/glyph_plotter.sv | 150 +++++++++++++++
 tb/tb_glyph_plotter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/glyph_plotter.sv
// Point FIFO with off-screen/repeat filtering in front of the 160x120 VGA
// adapter, plus a full-screen background clear sweep.
module glyph_plotter #(
    parameter int         DEPTH     = 8,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       in_valid,
    input  logic [7:0] in_x,
    input  logic [6:0] in_y,
    input  logic [2:0] in_colour,
    output logic       in_ready,
    input  logic       clear_req,
    input  logic       vga_ready,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       busy,
    output logic       clear_done
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [0:0] S_RUN   = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    logic [0:0]    state;
    logic [17:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          clear_pending;
    logic          last_valid;
    logic [17:0]   last_pt;

    logic [17:0] in_pt;
    logic        fifo_empty;
    logic        fifo_full;
    logic        on_screen;
    logic        dup;
    logic        push;
    logic        reg_free;
    logic        pop;
    logic        go_clear;

    assign in_pt      = {in_x, in_y, in_colour};
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == (AW+1)'(DEPTH));
    assign on_screen  = (in_x < 8'd160) && (in_y < 7'd120);
    assign dup        = last_valid && (in_pt == last_pt);

    assign in_ready = !fifo_full && (state == S_RUN) && !clear_pending;
    assign push     = in_valid && in_ready && on_screen && !dup;

    // Output register can take a new value when empty or handing off now
    assign reg_free = !vga_plot || vga_ready;
    assign pop      = (state == S_RUN) && !fifo_empty && reg_free;
    assign go_clear = (state == S_RUN) && clear_pending && fifo_empty && reg_free;

    assign busy = !fifo_empty || vga_plot || clear_pending || (state == S_CLEAR);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_pt;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_valid <= 1'b0;
            last_pt    <= '0;
        end else if (go_clear) begin
            last_valid <= 1'b0;
        end else if (push) begin
            last_valid <= 1'b1;
            last_pt    <= in_pt;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= S_RUN;
            clear_pending <= 1'b0;
            vga_x         <= '0;
            vga_y         <= '0;
            vga_colour    <= '0;
            vga_plot      <= 1'b0;
            clear_done    <= 1'b0;
        end else begin
            clear_done <= 1'b0;
            if (state == S_RUN) begin
                if (go_clear) begin
                    state         <= S_CLEAR;
                    clear_pending <= 1'b0;
                    vga_x         <= '0;
                    vga_y         <= '0;
                    vga_colour    <= BG_COLOUR;
                    vga_plot      <= 1'b1;
                end else begin
                    if (clear_req) begin
                        clear_pending <= 1'b1;
                    end
                    if (pop) begin
                        {vga_x, vga_y, vga_colour} <= mem[rd_ptr];
                        vga_plot <= 1'b1;
                    end else if (vga_ready) begin
                        vga_plot <= 1'b0;
                    end
                end
            end else if (vga_ready) begin
                // Sweep raster order; the last pixel hands back to RUN
                if (vga_x == 8'd159) begin
                    vga_x <= '0;
                    if (vga_y == 7'd119) begin
                        state      <= S_RUN;
                        vga_plot   <= 1'b0;
                        clear_done <= 1'b1;
                    end else begin
                        vga_y <= vga_y + 1'b1;
                    end
                end else begin
                    vga_x <= vga_x + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_glyph_plotter.sv
// Scoreboard bench for glyph_plotter: a point/clear reference model feeds an
// expected-write queue that a negedge monitor checks against the VGA port.
module tb_glyph_plotter;

    localparam logic [2:0] BG = 3'b000;

    logic       clk = 1'b0;
    logic       resetn;
    logic       in_valid;
    logic [7:0] in_x;
    logic [6:0] in_y;
    logic [2:0] in_colour;
    logic       in_ready;
    logic       clear_req;
    logic       vga_ready;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       busy;
    logic       clear_done;

    always #10 clk = ~clk;

    glyph_plotter #(.DEPTH(8), .BG_COLOUR(BG)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_x(in_x), .in_y(in_y),
        .in_colour(in_colour), .in_ready(in_ready),
        .clear_req(clear_req), .vga_ready(vga_ready),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .vga_plot(vga_plot), .busy(busy), .clear_done(clear_done)
    );

    int errors = 0;
    int checks = 0;

    logic [17:0] exp_q[$];
    bit          m_last_valid = 0;
    logic [17:0] m_last;
    bit          m_clr = 0;
    int          clr_target = 0;
    int          writes = 0;
    int          done_cnt = 0;
    bit          exp_done = 0;
    bit          prev_stall = 0;
    logic [17:0] prev_out;

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    // Reference model (inputs, clear requests) and output monitor
    always @(negedge clk) begin
        logic [17:0] pt;
        logic [17:0] e;
        if (!resetn) begin
            exp_q.delete();
            m_last_valid = 0;
            m_clr = 0;
            exp_done = 0;
            prev_stall = 0;
        end else begin
            if (in_valid && in_ready) begin
                pt = {in_x, in_y, in_colour};
                if (in_x < 160 && in_y < 120 && !(m_last_valid && pt == m_last)) begin
                    exp_q.push_back(pt);
                    m_last = pt;
                    m_last_valid = 1;
                end
            end
            if (clear_req && !m_clr) begin
                m_clr = 1;
                m_last_valid = 0;
                clr_target = writes + exp_q.size() + 19200;
                for (int yy = 0; yy < 120; yy++)
                    for (int xx = 0; xx < 160; xx++)
                        exp_q.push_back({8'(xx), 7'(yy), BG});
            end
            if (exp_done || clear_done) chk("clear_done", 32'(clear_done), 32'(exp_done));
            if (clear_done) done_cnt++;
            exp_done = 0;
            if (prev_stall)
                chk("stall_hold", {13'd0, vga_plot, vga_x, vga_y, vga_colour}, {13'd0, 1'b1, prev_out});
            if (vga_plot && vga_ready) begin
                pt = {vga_x, vga_y, vga_colour};
                writes++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got x=%0d y=%0d c=%0d want none", vga_x, vga_y, vga_colour);
                end else begin
                    e = exp_q.pop_front();
                    chk("write", 32'(pt), 32'(e));
                end
                if (m_clr && writes == clr_target) begin
                    m_clr = 0;
                    exp_done = 1;
                end
            end
            prev_stall = vga_plot && !vga_ready;
            prev_out = {vga_x, vga_y, vga_colour};
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(int x, int y, int c);
        in_valid = 1;
        in_x = 8'(x);
        in_y = 7'(y);
        in_colour = 3'(c);
    endtask

    task automatic wait_idle(string name, int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            step();
            n++;
        end
        chk(name, 32'(n < budget), 32'd1);
    endtask

    initial begin
        int w0;
        int d0;
        int n;
        int acc;
        int r;
        resetn = 0;
        in_valid = 0;
        in_x = 0;
        in_y = 0;
        in_colour = 0;
        clear_req = 0;
        vga_ready = 0;
        repeat (3) step();
        chk("reset_outputs", {12'd0, vga_x, vga_y, vga_colour, vga_plot, busy, clear_done}, 32'd0);
        resetn = 1;
        step();
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        vga_ready = 1;

        // Repeat suppression
        w0 = writes;
        drive(58, 29, 7);
        repeat (31) step();
        for (int x = 58; x <= 88; x++) begin
            drive(x, 29, 7);
            step();
        end
        in_valid = 0;
        wait_idle("repeat_drain", 200);
        chk("repeat_writes", 32'(writes - w0), 32'd31);

        // Single point latency
        w0 = writes;
        drive(58, 29, 7);
        chk("single_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 0;
        chk("single_lat1", 32'(vga_plot), 32'd0);
        step();
        chk("single_lat2", {13'd0, vga_plot, vga_x, vga_y, vga_colour},
            {13'd0, 1'b1, 8'd58, 7'd29, 3'd7});
        step();
        chk("single_pulse", 32'(vga_plot), 32'd0);
        wait_idle("single_drain", 50);
        chk("single_writes", 32'(writes - w0), 32'd1);

        // Off-screen points
        w0 = writes;
        drive(204, 102, 1);
        chk("off1_ready", 32'(in_ready), 32'd1);
        step();
        drive(10, 120, 2);
        chk("off2_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 0;
        repeat (3) step();
        chk("offscreen_idle", 32'(busy), 32'd0);
        chk("offscreen_writes", 32'(writes - w0), 32'd0);

        // Backpressure fill
        vga_ready = 0;
        acc = 0;
        n = 0;
        while (n < 20) begin
            drive(acc + 1, 100, 5);
            if (!in_ready) break;
            acc++;
            step();
            n++;
        end
        chk("bp_accepts", 32'(acc), 32'd9);
        repeat (3) step();
        chk("bp_full", 32'(in_ready), 32'd0);
        in_valid = 0;
        w0 = writes;
        vga_ready = 1;
        wait_idle("bp_drain", 100);
        chk("bp_writes", 32'(writes - w0), 32'd9);

        // Clear with queued points
        vga_ready = 0;
        drive(20, 30, 1);
        step();
        drive(21, 30, 2);
        step();
        drive(22, 31, 3);
        step();
        in_valid = 0;
        clear_req = 1;
        step();
        clear_req = 0;
        chk("clear_in_ready_low", 32'(in_ready), 32'd0);
        w0 = writes;
        d0 = done_cnt;
        vga_ready = 1;
        n = 0;
        while (done_cnt == d0 && n < 20000) begin
            step();
            n++;
        end
        chk("clear_timeout", 32'(n < 20000), 32'd1);
        step();
        chk("clear_writes", 32'(writes - w0), 32'd19203);
        chk("clear_done_count", 32'(done_cnt - d0), 32'd1);
        chk("post_clear_ready", 32'(in_ready), 32'd1);
        w0 = writes;
        drive(22, 31, 3);
        step();
        in_valid = 0;
        wait_idle("replot_drain", 50);
        chk("replot_writes", 32'(writes - w0), 32'd1);

        // Randomised traffic around edges and repeats
        for (int i = 0; i < 800; i++) begin
            in_valid = 1'($urandom % 2);
            r = $urandom % 8;
            in_x = 8'((r < 6) ? $urandom_range(0, 3) : $urandom_range(156, 163));
            r = $urandom % 8;
            in_y = 7'((r < 6) ? $urandom_range(0, 2) : $urandom_range(116, 123));
            in_colour = 3'($urandom % 2);
            vga_ready = ($urandom % 4) != 0;
            step();
        end
        in_valid = 0;
        vga_ready = 1;
        wait_idle("random_drain", 200);
        chk("random_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a clear
        clear_req = 1;
        step();
        clear_req = 0;
        n = 0;
        while (!(vga_plot && vga_x == 8'd40 && vga_y == 7'd60) && n < 20000) begin
            step();
            n++;
        end
        chk("midclear_reach", 32'(n < 20000), 32'd1);
        vga_ready = 0;
        @(negedge clk);
        #2;
        resetn = 0;
        #1;
        chk("midclear_reset_outputs", {12'd0, vga_x, vga_y, vga_colour, vga_plot, busy, clear_done}, 32'd0);
        repeat (2) step();
        resetn = 1;
        step();
        chk("midclear_in_ready", 32'(in_ready), 32'd1);
        w0 = writes;
        vga_ready = 1;
        repeat (50) step();
        chk("midclear_no_writes", 32'(writes - w0), 32'd0);
        chk("midclear_idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
